// File: rtl/aes_cipher_arbiter_if.sv
// Request, core and response signals shared by the AES arbiter and its
// environment.
interface aes_cipher_arbiter_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_key;
    logic [127:0] req0_text;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_key;
    logic [127:0] req1_text;
    logic         core_ld;
    logic [127:0] core_key;
    logic [127:0] core_text_in;
    logic         core_done;
    logic [127:0] core_text_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_id;
    logic         rsp_err;
    logic         busy;

    modport slave (
        input  req0_valid, req0_key, req0_text,
        input  req1_valid, req1_key, req1_text,
        input  core_done, core_text_out, rsp_ready,
        output req0_ready, req1_ready,
        output core_ld, core_key, core_text_in,
        output rsp_valid, rsp_data, rsp_id, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_key, req0_text,
        output req1_valid, req1_key, req1_text,
        output core_done, core_text_out, rsp_ready,
        input  req0_ready, req1_ready,
        input  core_ld, core_key, core_text_in,
        input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
    );
endinterface

// File: rtl/aes_cipher_arbiter.sv
// Round-robin sharing of one AES-128 core between two requesters,
// with a timeout guard and a tagged valid/ready response channel.
module aes_cipher_arbiter #(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_cipher_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BUSY,
        S_RESP
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     text_q, text_d;
    logic [127:0]     data_q, data_d;
    logic             id_q, id_d;
    logic             err_q, err_d;

    logic grant;
    logic acc0;
    logic acc1;

    // A lone requester always wins; a tie goes to the port not served last.
    always_comb begin
        grant = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end
    end

    assign acc0 = (state_q == S_IDLE) && !grant && bus.req0_valid;
    assign acc1 = (state_q == S_IDLE) && grant && bus.req1_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        text_d       = text_q;
        data_d       = data_q;
        id_d         = id_q;
        err_d        = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (acc0 || acc1) begin
                    key_d   = acc1 ? bus.req1_key : bus.req0_key;
                    text_d  = acc1 ? bus.req1_text : bus.req0_text;
                    id_d    = acc1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.core_done) begin
                    data_d  = bus.core_text_out;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    last_grant_d = id_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            key_q        <= '0;
            text_q       <= '0;
            data_q       <= '0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            text_q       <= text_d;
            data_q       <= data_d;
            id_q         <= id_d;
            err_q        <= err_d;
        end
    end

    assign bus.req0_ready   = acc0;
    assign bus.req1_ready   = acc1;
    assign bus.core_ld      = (state_q == S_LOAD);
    assign bus.core_key     = key_q;
    assign bus.core_text_in = text_q;
    assign bus.rsp_valid    = (state_q == S_RESP);
    assign bus.rsp_data     = data_q;
    assign bus.rsp_id       = id_q;
    assign bus.rsp_err      = err_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule
